product_accumulator: RTL and testbench

- Downstream consumer of the combinational multiplier's 8-bit product P.
- Registers and sums a fixed number of consecutive products (COUNT) into a wider accumulator.
- Presents each finished sum on a valid/ready output port, then starts the next batch.
- Turns the multiplier into a dot-product / MAC datapath stage.

---
 rtl/product_acc_pkg.sv | 32 +++
 rtl/product_accumulator_if.sv | 27 ++
 rtl/product_accumulator.sv | 84 ++++++++
 tb/tb_product_accumulator.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/product_acc_pkg.sv
// Shared types and helpers for the product accumulator.
// Saturation is selected per build by PRODUCT_ACCUMULATOR_SAT_EN in the top module.
package product_acc_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int unsigned P_W_DEF   = 8;
    localparam int unsigned ACC_W_DEF = 10;
    localparam int unsigned SUM_MAX_W = 32;

    // Adds at w bits and returns {carry, sum}; sum is clamped to all-ones on carry when sat is set.
    function automatic logic [SUM_MAX_W:0] sat_add(
        input logic [SUM_MAX_W-1:0] a,
        input logic [SUM_MAX_W-1:0] b,
        input int unsigned          w,
        input logic                 sat
    );
        logic [SUM_MAX_W:0]   full;
        logic [SUM_MAX_W:0]   mask;
        logic                 carry;
        logic [SUM_MAX_W-1:0] sum;
        full  = {1'b0, a} + {1'b0, b};
        mask  = ({{SUM_MAX_W{1'b0}}, 1'b1} << w) - {{SUM_MAX_W{1'b0}}, 1'b1};
        carry = full[w[5:0]];
        sum   = (sat && carry) ? mask[SUM_MAX_W-1:0] : (full[SUM_MAX_W-1:0] & mask[SUM_MAX_W-1:0]);
        return {carry, sum};
    endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product input and batch-sum output handshakes of the product accumulator.
interface product_accumulator_if #(
    parameter int unsigned P_W   = 8,
    parameter int unsigned ACC_W = 10,
    parameter int unsigned COUNT = 4
);
    localparam int unsigned CNT_W = $clog2(COUNT + 1);

    logic             in_valid;
    logic             in_ready;
    logic [P_W-1:0]   p_in;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             overflow;
    logic [CNT_W-1:0] cnt;

    modport master (
        output in_valid, p_in, out_ready,
        input  in_ready, out_valid, acc_out, overflow, cnt
    );

    modport slave (
        input  in_valid, p_in, out_ready,
        output in_ready, out_valid, acc_out, overflow, cnt
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums COUNT consecutive products and hands each batch sum off on a valid/ready port.
// Define PRODUCT_ACCUMULATOR_SAT_EN to clamp the sum on overflow instead of wrapping.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int unsigned P_W   = P_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned COUNT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    product_accumulator_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(COUNT + 1);

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;
    logic               accept;
    logic [SUM_MAX_W:0] add_res;
    logic               carry;
    logic [ACC_W-1:0]   sum;
    logic               unused_add_hi;

    always_comb begin
        add_res       = sat_add(SUM_MAX_W'(acc), SUM_MAX_W'(bus.p_in), ACC_W, SAT);
        carry         = add_res[SUM_MAX_W];
        sum           = add_res[ACC_W-1:0];
        unused_add_hi = ^add_res[SUM_MAX_W-1:ACC_W];
    end

    // clear wins over an accept in the same cycle, so the sample is dropped.
    assign accept = bus.in_valid && (state == ACCUM) && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc <= sum;
                        cnt <= cnt + CNT_W'(1);
                        ovf <= ovf | carry;
                        if (cnt == CNT_W'(COUNT - 1))
                            state <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state <= ACCUM;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == HOLD);
    assign bus.acc_out   = acc;
    assign bus.cnt       = cnt;
    assign bus.overflow  = ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a 10-bit and a 9-bit accumulator instance.
// Overflow expectations follow PRODUCT_ACCUMULATOR_SAT_EN.
module tb_product_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr10 = 1'b0;
    logic clr9 = 1'b0;
    int unsigned passed = 0;
    int unsigned total = 0;

    product_accumulator_if #(.P_W(8), .ACC_W(10), .COUNT(4)) b10 ();
    product_accumulator_if #(.P_W(8), .ACC_W(9), .COUNT(4)) b9 ();

    product_accumulator #(.P_W(8), .ACC_W(10), .COUNT(4)) dut10 (
        .clk(clk), .rst(rst), .clear(clr10), .bus(b10)
    );
    product_accumulator #(.P_W(8), .ACC_W(9), .COUNT(4)) dut9 (
        .clk(clk), .rst(rst), .clear(clr9), .bus(b9)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        b10.in_valid = 1'b1; b10.p_in = 8'd50; b10.out_ready = 1'b0;
        step();
        total++;
        if (b10.acc_out !== 10'd50) $display("FAIL reset_pre_acc: got %0d want 50", b10.acc_out);
        else passed++;
        b10.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({b10.acc_out, b10.cnt, b10.out_valid, b10.in_ready, b10.overflow} !== {10'd0, 3'd0, 1'b0, 1'b1, 1'b0})
            $display("FAIL reset_async: acc=%0d cnt=%0d ov=%b ir=%b of=%b want 0 0 0 1 0",
                     b10.acc_out, b10.cnt, b10.out_valid, b10.in_ready, b10.overflow);
        else passed++;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [7:0] vals [4] = '{8'd105, 8'd42, 8'd0, 8'd15};
        int unsigned exp_sum [4] = '{105, 147, 147, 162};
        b10.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b10.in_valid = 1'b1; b10.p_in = vals[i];
            step();
            total++;
            if (b10.acc_out !== 10'(exp_sum[i]) || b10.cnt !== 3'(i + 1))
                $display("FAIL basic_acc%0d: acc=%0d cnt=%0d want %0d %0d", i, b10.acc_out, b10.cnt, exp_sum[i], i + 1);
            else passed++;
        end
        total++;
        if (b10.out_valid !== 1'b1 || b10.in_ready !== 1'b0 || b10.acc_out !== 10'd162)
            $display("FAIL basic_hold: ov=%b ir=%b acc=%0d want 1 0 162", b10.out_valid, b10.in_ready, b10.acc_out);
        else passed++;
        b10.p_in = 8'd20;
        step();
        total++;
        if (b10.out_valid !== 1'b0 || b10.in_ready !== 1'b1 || b10.acc_out !== 10'd0 || b10.cnt !== 3'd0)
            $display("FAIL basic_handoff: ov=%b ir=%b acc=%0d cnt=%0d want 0 1 0 0",
                     b10.out_valid, b10.in_ready, b10.acc_out, b10.cnt);
        else passed++;
        step();
        total++;
        if (b10.acc_out !== 10'd20 || b10.cnt !== 3'd1)
            $display("FAIL basic_next: acc=%0d cnt=%0d want 20 1", b10.acc_out, b10.cnt);
        else passed++;
        b10.in_valid = 1'b0; clr10 = 1'b1;
        step();
        clr10 = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] vals [4] = '{8'd105, 8'd42, 8'd0, 8'd15};
        b10.out_ready = 1'b0;
        b10.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b10.p_in = vals[i];
            step();
        end
        b10.p_in = 8'd99;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (b10.out_valid !== 1'b1 || b10.in_ready !== 1'b0 || b10.acc_out !== 10'd162 || b10.cnt !== 3'd4)
                $display("FAIL bp_hold%0d: ov=%b ir=%b acc=%0d cnt=%0d want 1 0 162 4",
                         i, b10.out_valid, b10.in_ready, b10.acc_out, b10.cnt);
            else passed++;
            step();
        end
        b10.out_ready = 1'b1;
        step();
        total++;
        if (b10.acc_out !== 10'd0 || b10.cnt !== 3'd0 || b10.out_valid !== 1'b0)
            $display("FAIL bp_handoff: acc=%0d cnt=%0d ov=%b want 0 0 0", b10.acc_out, b10.cnt, b10.out_valid);
        else passed++;
        step();
        total++;
        if (b10.acc_out !== 10'd99 || b10.cnt !== 3'd1)
            $display("FAIL bp_consume: acc=%0d cnt=%0d want 99 1", b10.acc_out, b10.cnt);
        else passed++;
        b10.in_valid = 1'b0; clr10 = 1'b1;
        step();
        clr10 = 1'b0;
    endtask

    task automatic test_gaps();
        logic vld [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        int unsigned exp_cnt [7] = '{1, 1, 1, 2, 2, 3, 4};
        b10.out_ready = 1'b0;
        b10.p_in = 8'd10;
        for (int i = 0; i < 7; i++) begin
            b10.in_valid = vld[i];
            step();
            total++;
            if (b10.cnt !== 3'(exp_cnt[i]) || b10.out_valid !== (i == 6))
                $display("FAIL gaps_cnt%0d: cnt=%0d ov=%b want %0d %b", i, b10.cnt, b10.out_valid, exp_cnt[i], i == 6);
            else passed++;
        end
        total++;
        if (b10.acc_out !== 10'd40) $display("FAIL gaps_sum: got %0d want 40", b10.acc_out);
        else passed++;
        b10.in_valid = 1'b0; b10.out_ready = 1'b1;
        step();
    endtask

    task automatic test_overflow();
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
        int unsigned exp_sum [4] = '{255, 510, 511, 511};
`else
        int unsigned exp_sum [4] = '{255, 510, 253, 508};
`endif
        logic exp_of [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        b9.out_ready = 1'b0;
        b9.in_valid = 1'b1;
        b9.p_in = 8'd255;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (b9.acc_out !== 9'(exp_sum[i]) || b9.overflow !== exp_of[i])
                $display("FAIL ovf_step%0d: acc=%0d of=%b want %0d %b", i, b9.acc_out, b9.overflow, exp_sum[i], exp_of[i]);
            else passed++;
        end
        total++;
        if (b9.out_valid !== 1'b1) $display("FAIL ovf_hold: ov=%b want 1", b9.out_valid);
        else passed++;
        b9.in_valid = 1'b0; b9.out_ready = 1'b1;
        step();
        total++;
        if (b9.overflow !== 1'b0 || b9.acc_out !== 9'd0)
            $display("FAIL ovf_handoff: of=%b acc=%0d want 0 0", b9.overflow, b9.acc_out);
        else passed++;
    endtask

    task automatic test_clear();
        b10.out_ready = 1'b0;
        b10.in_valid = 1'b1; b10.p_in = 8'd7;
        step();
        step();
        total++;
        if (b10.acc_out !== 10'd14 || b10.cnt !== 3'd2)
            $display("FAIL clr_pre: acc=%0d cnt=%0d want 14 2", b10.acc_out, b10.cnt);
        else passed++;
        clr10 = 1'b1;
        total++;
        if (b10.in_ready !== 1'b1) $display("FAIL clr_ready: ir=%b want 1", b10.in_ready);
        else passed++;
        step();
        clr10 = 1'b0; b10.in_valid = 1'b0;
        total++;
        if (b10.acc_out !== 10'd0 || b10.cnt !== 3'd0 || b10.out_valid !== 1'b0)
            $display("FAIL clr_mid: acc=%0d cnt=%0d ov=%b want 0 0 0", b10.acc_out, b10.cnt, b10.out_valid);
        else passed++;
        b10.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) step();
        b10.in_valid = 1'b0;
        total++;
        if (b10.out_valid !== 1'b1 || b10.acc_out !== 10'd28)
            $display("FAIL clr_hold_pre: ov=%b acc=%0d want 1 28", b10.out_valid, b10.acc_out);
        else passed++;
        clr10 = 1'b1;
        step();
        clr10 = 1'b0;
        total++;
        if (b10.acc_out !== 10'd0 || b10.cnt !== 3'd0 || b10.out_valid !== 1'b0 || b10.in_ready !== 1'b1)
            $display("FAIL clr_hold: acc=%0d cnt=%0d ov=%b ir=%b want 0 0 0 1",
                     b10.acc_out, b10.cnt, b10.out_valid, b10.in_ready);
        else passed++;
    endtask

    initial begin
        b10.in_valid = 1'b0; b10.p_in = '0; b10.out_ready = 1'b0;
        b9.in_valid = 1'b0; b9.p_in = '0; b9.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_overflow();
        test_clear();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
